pergate_sequencer: RTL

Initiator/controller for a bank of pergate_compute units during one sumcheck layer.
- Accepts one verifier challenge tau per round over a valid/ready handshake and computes m_tau_p1 = 1 - tau mod F_Q.
- Pulses en (with restart on round 0) and presents the per-round precomp bit.
- Waits until every unit reports ready, then advances the round.
- Sits between the verifier-challenge interface and all pergate_compute instances of a layer.

---
 rtl/pergate_sequencer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pergate_sequencer.sv
// Round sequencer for one sumcheck layer of pergate_compute units: takes tau, issues en/restart/precomp, waits for all units.
// Optional PERGATE_SEQ_TAUCHECK_EN: out-of-field tau is consumed without loading and flagged on tau_err.
module pergate_sequencer #(
  parameter int                 nunits      = 2,
  parameter int                 nrounds     = 9,
  parameter logic [nrounds-1:0] precomp_dfl = 9'o003,
  parameter int                 F_NBITS     = 61,
  parameter logic [F_NBITS-1:0] F_Q         = 61'h1FFF_FFFF_FFFF_FFFF,
  localparam int                RW          = $clog2(nrounds+1)
) (
  input  logic               clk,
  input  logic               rstb,
  input  logic               start,
  input  logic [F_NBITS-1:0] tau_in,
  input  logic               tau_valid,
  output logic               tau_ready,
  input  logic [nunits-1:0]  unit_ready,
  output logic               en,
  output logic               restart,
  output logic               precomp,
  output logic [F_NBITS-1:0] tau,
  output logic [F_NBITS-1:0] m_tau_p1,
  output logic [RW-1:0]      round,
  output logic               busy,
  output logic               done
`ifdef PERGATE_SEQ_TAUCHECK_EN
  , output logic             tau_err
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_TAU, S_ISSUE, S_GUARD, S_WAIT_RDY, S_DONE} state_t;

  state_t             state;
  logic [nrounds-1:0] shreg;
  logic [F_NBITS-1:0] mtp_next;
  logic               all_rdy, last_round, tau_ok;

  assign all_rdy    = &unit_ready;
  assign last_round = (round == RW'(nrounds-1));
  // F_Q+1-tau wraps identically whether done in F_NBITS or F_NBITS+1 bits.
  assign mtp_next   = (tau_in == '0)               ? F_NBITS'(1) :
                      (tau_in == F_NBITS'(1))      ? '0 :
                      F_Q + F_NBITS'(1) - tau_in;
`ifdef PERGATE_SEQ_TAUCHECK_EN
  assign tau_ok = (tau_in < F_Q);
`else
  assign tau_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state     <= S_IDLE;
      shreg     <= '0;
      tau_ready <= 1'b0;
      en        <= 1'b0;
      restart   <= 1'b0;
      precomp   <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      tau       <= '0;
      m_tau_p1  <= '0;
      round     <= '0;
`ifdef PERGATE_SEQ_TAUCHECK_EN
      tau_err   <= 1'b0;
`endif
    end else begin
      en      <= 1'b0;
      restart <= 1'b0;
      precomp <= 1'b0;
      done    <= 1'b0;
`ifdef PERGATE_SEQ_TAUCHECK_EN
      tau_err <= 1'b0;
`endif
      case (state)
        S_IDLE: if (start) begin
          shreg     <= precomp_dfl;
          round     <= '0;
          busy      <= 1'b1;
          tau_ready <= 1'b1;
          state     <= S_WAIT_TAU;
        end
        // tau_ready is high throughout this state, so tau_valid alone completes the handshake.
        S_WAIT_TAU: begin
          if (tau_valid && tau_ok) begin
            tau       <= tau_in;
            m_tau_p1  <= mtp_next;
            tau_ready <= 1'b0;
            en        <= 1'b1;
            restart   <= (round == '0);
            precomp   <= shreg[0];
            state     <= S_ISSUE;
          end
`ifdef PERGATE_SEQ_TAUCHECK_EN
          else if (tau_valid) tau_err <= 1'b1;
`endif
        end
        S_ISSUE: state <= S_GUARD;
        // Units may still show the previous round's ready here; skip it.
        S_GUARD: state <= S_WAIT_RDY;
        S_WAIT_RDY: if (all_rdy) begin
          shreg <= shreg >> 1;
          round <= round + RW'(1);
          if (last_round) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            tau_ready <= 1'b1;
            state     <= S_WAIT_TAU;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
